// File: rtl/sprite_rom_arbiter.sv
// Two-port round-robin arbiter for a shared single-port sprite ROM; SPRITE_ARB_LOCK_EN enables burst lock.
// Latency: 3 cycles from req to validX. Throughput: one read per cycle.
// Backpressure: none; a requester is only stalled by losing arbitration (no grant).
module sprite_rom_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
) (
    input  logic              clk60MHz,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [1:0]        lock,
    output logic [1:0]        gnt,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_rgb,
    output logic [DATA_W-1:0] rgb0,
    output logic [DATA_W-1:0] rgb1,
    output logic              valid0,
    output logic              valid1
);

    logic       last;
    logic [1:0] rr_win;
    logic [1:0] win;
    logic       tag1_vld, tag1_id;
    logic       tag2_vld, tag2_id;

    // last==1 means requester 1 was served most recently, so 0 wins a tie.
    always_comb begin
        rr_win = 2'b00;
        case (req)
            2'b01:   rr_win = 2'b01;
            2'b10:   rr_win = 2'b10;
            2'b11:   rr_win = last ? 2'b01 : 2'b10;
            default: rr_win = 2'b00;
        endcase
    end

`ifdef SPRITE_ARB_LOCK_EN
    // A holder that keeps both lock and req asserted keeps the ROM regardless of the other side.
    always_comb begin
        win = rr_win;
        if (gnt[0] && lock[0] && req[0])
            win = 2'b01;
        else if (gnt[1] && lock[1] && req[1])
            win = 2'b10;
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign win = rr_win;
`endif

    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            gnt         <= 2'b00;
            rom_address <= '0;
            last        <= 1'b1;
        end else begin
            gnt <= win;
            if (win != 2'b00) begin
                last        <= win[1];
                rom_address <= win[1] ? addr1 : addr0;
            end
        end
    end

    // Tag follows each accepted read through the ROM's registered read stage.
    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            tag1_vld <= 1'b0;
            tag1_id  <= 1'b0;
            tag2_vld <= 1'b0;
            tag2_id  <= 1'b0;
        end else begin
            tag1_vld <= (win != 2'b00);
            tag1_id  <= win[1];
            tag2_vld <= tag1_vld;
            tag2_id  <= tag1_id;
        end
    end

    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            rgb0   <= '0;
            rgb1   <= '0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
        end else begin
            valid0 <= tag2_vld && !tag2_id;
            valid1 <= tag2_vld && tag2_id;
            if (tag2_vld && !tag2_id)
                rgb0 <= rom_rgb;
            if (tag2_vld && tag2_id)
                rgb1 <= rom_rgb;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized and directed bench for sprite_rom_arbiter against a scoreboard model of the arbitration rules.
module tb_sprite_rom_arbiter;

    logic        clk60MHz = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [11:0] addr0 = '0;
    logic [11:0] addr1 = '0;
    logic [1:0]  lock = 2'b00;
    logic [1:0]  gnt;
    logic [11:0] rom_address;
    logic [11:0] rom_rgb = '0;
    logic [11:0] rgb0, rgb1;
    logic        valid0, valid1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [11:0] rom_mem [4096];

    typedef struct {
        int          due;
        logic [11:0] data;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    // Model state
    logic        m_last;
    logic [1:0]  m_gnt;
    logic [11:0] m_addr;
    logic [11:0] m_rgb0, m_rgb1;

    sprite_rom_arbiter #(.ADDR_W(12), .DATA_W(12)) dut (
        .clk60MHz    (clk60MHz),
        .rst         (rst),
        .req         (req),
        .addr0       (addr0),
        .addr1       (addr1),
        .lock        (lock),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_rgb     (rom_rgb),
        .rgb0        (rgb0),
        .rgb1        (rgb1),
        .valid0      (valid0),
        .valid1      (valid1)
    );

    always #5 clk60MHz = ~clk60MHz;

    // Shared ROM: one-cycle registered read
    always @(posedge clk60MHz) rom_rgb <= rom_mem[rom_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_gnt  = 2'b00;
        m_addr = '0;
        m_rgb0 = '0;
        m_rgb1 = '0;
        q0.delete();
        q1.delete();
    endtask

    // One clock: apply inputs, predict the grant, advance, then compare every output.
    task automatic cycle(input logic [1:0] r, input logic [11:0] a0, input logic [11:0] a1,
                         input logic [1:0] lk);
        logic [1:0] w;
        logic       e0, e1;
        req = r; addr0 = a0; addr1 = a1; lock = lk;
        if (r == 2'b11) w = m_last ? 2'b01 : 2'b10;
        else            w = r;
`ifdef SPRITE_ARB_LOCK_EN
        if ((m_gnt & lk & r) != 2'b00) w = m_gnt;
`endif
        @(posedge clk60MHz);
        #1;
        cyc++;
        m_gnt = w;
        if (w == 2'b01) begin
            m_last = 1'b0; m_addr = a0;
            q0.push_back('{due: cyc + 2, data: rom_mem[a0]});
        end else if (w == 2'b10) begin
            m_last = 1'b1; m_addr = a1;
            q1.push_back('{due: cyc + 2, data: rom_mem[a1]});
        end
        e0 = (q0.size() > 0) && (q0[0].due == cyc);
        e1 = (q1.size() > 0) && (q1[0].due == cyc);
        if (e0) begin m_rgb0 = q0[0].data; void'(q0.pop_front()); end
        if (e1) begin m_rgb1 = q1[0].data; void'(q1.pop_front()); end
        chk("gnt", gnt, m_gnt);
        chk("rom_address", rom_address, m_addr);
        chk("valid0", valid0, e0);
        chk("valid1", valid1, e1);
        chk("rgb0", rgb0, m_rgb0);
        chk("rgb1", rgb1, m_rgb1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_rom_address"}, rom_address, 0);
        chk({tag, "_rgb0"}, rgb0, 0);
        chk({tag, "_rgb1"}, rgb1, 0);
        chk({tag, "_valid0"}, valid0, 0);
        chk({tag, "_valid1"}, valid1, 0);
    endtask

    // Assert rst mid-cycle while both sides are streaming, then release with idle inputs.
    task automatic mid_reset();
        cycle(2'b11, 12'h111, 12'h222, 2'b00);
        cycle(2'b11, 12'h333, 12'h444, 2'b00);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        req = 2'b00;
        @(posedge clk60MHz);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(2'b00, 12'h0, 12'h0, 2'b00);
    endtask

    logic [1:0] seq_contend [6];
    logic [1:0] seq_lock [5];

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 12'($urandom);
        rom_mem[12'h041] = 12'hF80;
        seq_contend = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`ifdef SPRITE_ARB_LOCK_EN
        seq_lock = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`else
        seq_lock = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
        model_reset();

        // Power-on reset
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk60MHz);
        #1;
        rst = 1'b0;

        // Single requester, known ROM word
        cycle(2'b01, 12'h041, 12'h0, 2'b00);
        chk("single_gnt", gnt, 2'b01);
        chk("single_addr", rom_address, 12'h041);
        cycle(2'b00, 12'h0, 12'h0, 2'b00);
        cycle(2'b00, 12'h0, 12'h0, 2'b00);
        chk("single_valid0", valid0, 1);
        chk("single_rgb0", rgb0, 12'hF80);
        chk("single_valid1", valid1, 0);

        // Contention straight after reset
        mid_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(2'b11, 12'(16 + i), 12'(32 + i), 2'b00);
            chk("contend_gnt", gnt, seq_contend[i]);
        end
        for (int i = 0; i < 3; i++) cycle(2'b00, 12'h0, 12'h0, 2'b00);

        // Idle gap after requester 1 was served: requester 0 wins next tie
        cycle(2'b10, 12'h0, 12'h0AB, 2'b00);
        cycle(2'b00, 12'h0, 12'h0, 2'b00);
        cycle(2'b00, 12'h0, 12'h0, 2'b00);
        cycle(2'b11, 12'h0CD, 12'h0EF, 2'b00);
        chk("idle_gap_gnt", gnt, 2'b01);

        // Lock burst
        mid_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(2'b11, 12'(64 + i), 12'(96 + i), (i < 4) ? 2'b01 : 2'b00);
            chk("lock_gnt", gnt, seq_lock[i]);
        end
        for (int i = 0; i < 3; i++) cycle(2'b00, 12'h0, 12'h0, 2'b00);

        // Random traffic
        for (int i = 0; i < 10000; i++)
            cycle(2'($urandom), 12'($urandom), 12'($urandom), 2'($urandom));
        for (int i = 0; i < 4; i++) cycle(2'b00, 12'h0, 12'h0, 2'b00);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, ROM address width ({addry[5:0], addrx[5:0]}).
REQ-002 The block SHALL have parameter DATA_W, default 12, pixel width (4:4:4 RGB).
REQ-003 clk60MHz  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  per-requester read request; bit i belongs to requester i.
REQ-006 addr0, addr1  input  ADDR_W  read address of requester 0 and 1.
REQ-007 lock  input  2  per-requester burst-lock request; used only when SPRITE_ARB_LOCK_EN is defined.
REQ-008 gnt  output  2  one-hot-or-zero grant; gnt[i]=1 in cycle N+1 means addr_i sampled at end of cycle N was accepted.
REQ-009 rom_address  output  ADDR_W  address to the shared single-port sprite ROM (1-cycle registered read).
REQ-010 rom_rgb  input  DATA_W  ROM read data, valid one cycle after rom_address.
REQ-011 rgb0, rgb1  output  DATA_W  returned pixel per requester.
REQ-012 valid0, valid1  output  1  single-cycle strobe qualifying rgb0 / rgb1.

Function
REQ-013 Arbitration SHALL be decided once per cycle from req sampled at the clock edge; at most one grant per cycle.
REQ-014 Single request: the requesting side SHALL win.
REQ-015 Both requesting: winner SHALL be the requester not granted most recently (round-robin pointer `last`).
REQ-016 `last` SHALL update only on a granting cycle; idle cycles leave it unchanged.
REQ-017 On grant, rom_address SHALL register the winner's address; with no request, rom_address SHALL hold its previous value and gnt=2'b00.
REQ-018 A 2-stage tag pipeline (valid bit + winner id) SHALL track each accepted read: grant at edge E -> ROM sampled at edge E+1 -> rom_rgb captured into rgbX with validX=1 at edge E+2.
REQ-019 Latency SHALL be exactly 3 cycles from req asserted (cycle N) to validX high (cycle N+3); throughput one read per cycle.
REQ-020 rgbX SHALL hold its last value when validX is low; only the tagged requester's rgb/valid updates.
REQ-021 Continuous req on both sides SHALL produce strictly alternating gnt 01,10,01,... with no idle cycle.
REQ-022 A requester SHALL NOT be starved: with both requesting, each wins within 2 cycles.

Reset
REQ-023 While rst=1 (asynchronously): gnt=0, rom_address=0, rgb0=rgb1=0, valid0=valid1=0, tag pipeline cleared, `last`=1 (requester 0 wins first contention).
REQ-024 Reads in flight at reset assertion SHALL be discarded; no valid strobe after rst deasserts unless a new grant occurs.
REQ-025 First arbitration SHALL occur at the first rising edge after rst deasserts.

Configuration
REQ-026 Macro SPRITE_ARB_LOCK_EN: when defined, a requester granted in cycle N with lock[i]=1 and req[i]=1 at the next edge SHALL be granted again regardless of the other request (burst of consecutive ROM rows); lock release returns to round-robin with `last`=that requester.
REQ-027 When SPRITE_ARB_LOCK_EN is undefined, the lock input SHALL be ignored and behaviour SHALL be pure round-robin per REQ-015.

Verification
REQ-028 Reset: assert rst mid-stream with both req high -> all outputs 0 within same cycle, no valid for 3 cycles after release without req.
REQ-029 Single requester: req=01, addr0=12'h041, ROM[041]=12'hF80 -> gnt=01 cycle N+1, rom_address=041, rgb0=F80 with valid0=1 in cycle N+3, valid1=0.
REQ-030 Contention: req=11 for 6 cycles after reset -> gnt 01,10,01,10,01,10; valids alternate 3 cycles later with correct per-side data.
REQ-031 Idle gap: req=10, idle 2 cycles, then req=11 -> first contended grant goes to requester 0.
REQ-032 Lock (macro defined): req=11, lock=01 for 4 cycles -> gnt=01 on 4 consecutive cycles, then 10; macro undefined -> alternating grants.
REQ-033 Data integrity: random req/addr for 10k cycles against a ROM model -> every accepted address returned once, in order per requester, on the right port.
